// File: rtl/fp16_pkg.sv
// Shared constants, FSM encoding and result-flag bundle for the half-precision divider.
package fp16_pkg;

  localparam logic [4:0]  BIAS         = 5'd15;
  localparam logic [4:0]  EXP_MAX      = 5'd30;
  localparam logic [4:0]  EXP_MIN      = 5'd1;
  localparam logic [15:0] QNAN         = 16'h7E00;
  localparam logic [4:0]  EXP_ALL_ONES = 5'h1F;

  localparam logic [3:0]  LAST_ITER    = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic ovf;
    logic unf;
    logic dbz;
  } fp_flags_t;

endpackage

// File: rtl/division_normalizer.sv
// Combinational exponent adjust, mantissa normalization and special-case selection.
module division_normalizer
  import fp16_pkg::*;
(
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  input  logic [11:0] quo_i,
  output logic [15:0] result_o,
  output fp_flags_t   flags_o
);

  logic              sign;
  logic              nan1, nan2, inf1, inf2, zero1, zero2;
  logic signed [6:0] exp_raw;
  logic signed [6:0] exp_norm;
  logic [9:0]        mant;

  assign sign  = op1_i[15] ^ op2_i[15];
  assign nan1  = (op1_i[14:10] == EXP_ALL_ONES) && (op1_i[9:0] != 10'h0);
  assign nan2  = (op2_i[14:10] == EXP_ALL_ONES) && (op2_i[9:0] != 10'h0);
  assign inf1  = (op1_i[14:10] == EXP_ALL_ONES) && (op1_i[9:0] == 10'h0);
  assign inf2  = (op2_i[14:10] == EXP_ALL_ONES) && (op2_i[9:0] == 10'h0);
  assign zero1 = (op1_i[14:0] == 15'h0);
  assign zero2 = (op2_i[14:0] == 15'h0);

  // Quotient lies in [2^10, 2^12): bit 11 tells whether a one-place shift is needed.
  assign exp_raw  = {2'b00, op1_i[14:10]} - {2'b00, op2_i[14:10]} + {2'b00, BIAS};
  assign exp_norm = quo_i[11] ? exp_raw : exp_raw - 7'sd1;
  assign mant     = quo_i[11] ? quo_i[10:1] : quo_i[9:0];

  always_comb begin
    flags_o  = '0;
    result_o = {sign, exp_norm[4:0], mant};
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      flags_o.nan = 1'b1;
      result_o    = {sign, QNAN[14:0]};
    end else if (inf1 || zero2) begin
      flags_o.inf = 1'b1;
      flags_o.dbz = zero2 && !inf1;
      result_o    = {sign, EXP_ALL_ONES, 10'h0};
    end else if (zero1 || inf2) begin
      flags_o.zero = 1'b1;
      result_o     = {sign, 15'h0};
    end else if (exp_norm > $signed({2'b00, EXP_MAX})) begin
      flags_o.ovf = 1'b1;
      result_o    = {sign, EXP_ALL_ONES, 10'h0};
    end else if (exp_norm < $signed({2'b00, EXP_MIN})) begin
      flags_o.unf = 1'b1;
      result_o    = {sign, 15'h0};
    end
  end

endmodule

// File: rtl/floating_point_16bit_divider.sv
// Half-precision divider: restoring mantissa division, one quotient bit per cycle,
// fixed 14-cycle latency from accepted start to the done pulse for every operand class.
module floating_point_16bit_divider
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] operand1,
  input  logic [15:0] operand2,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        underflow,
  output logic        NaN,
  output logic        infinity,
  output logic        div_by_zero
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] op1_q, op2_q;
  logic [11:0] rem_q, quo_q;
  logic [15:0] result_q, norm_result;
  fp_flags_t   flags_q, norm_flags;
  logic [11:0] divisor;
  logic        ge;
  logic [10:0] rem_sub;

  assign divisor = {2'b01, op2_q[9:0]};
  assign ge      = rem_q >= divisor;
  assign rem_sub = 11'(ge ? rem_q - divisor : rem_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIVIDE;
      DIVIDE:  if (cnt_q == LAST_ITER) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DIVIDE count 0 loads the dividend mantissa; counts 1..12 each retire one quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op1_q <= operand1;
        op2_q <= operand2;
        cnt_q <= '0;
      end
      if (state_q == DIVIDE) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          rem_q <= {2'b01, op1_q[9:0]};
          quo_q <= '0;
        end else begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[10:0], ge};
        end
      end
      if (state_q == NORM) begin
        result_q <= norm_result;
        flags_q  <= norm_flags;
      end
    end
  end

  division_normalizer u_norm (
    .op1_i    (op1_q),
    .op2_i    (op2_q),
    .quo_i    (quo_q),
    .result_o (norm_result),
    .flags_o  (norm_flags)
  );

  assign busy        = (state_q == DIVIDE) || (state_q == NORM);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign NaN         = flags_q.nan;
  assign infinity    = flags_q.inf;
  assign zero        = flags_q.zero;
  assign overflow    = flags_q.ovf;
  assign underflow   = flags_q.unf;
  assign div_by_zero = flags_q.dbz;

endmodule

// File: tb/tb_floating_point_16bit_divider.sv
// Scoreboard bench for the half-precision divider: directed vectors, decoupled monitor.
module tb_floating_point_16bit_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] operand1 = '0;
  logic [15:0] operand2 = '0;
  logic        busy, done, zero, overflow, underflow, NaN, infinity, div_by_zero;
  logic [15:0] result;

  // Flag vector order: {NaN, infinity, zero, overflow, underflow, div_by_zero}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_NAN  = 6'b100000;
  localparam logic [5:0] F_INF  = 6'b010000;
  localparam logic [5:0] F_ZERO = 6'b001000;
  localparam logic [5:0] F_OVF  = 6'b000100;
  localparam logic [5:0] F_UNF  = 6'b000010;
  localparam logic [5:0] F_DBZ  = 6'b000001;

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic [5:0]  flg;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  floating_point_16bit_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .operand1    (operand1),
    .operand2    (operand2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .underflow   (underflow),
    .NaN         (NaN),
    .infinity    (infinity),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] flags_now();
    return {NaN, infinity, zero, overflow, underflow, div_by_zero};
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done pulse at cycle %0d with no pending operation", cyc);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (result !== e.res) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", e.nm, result, e.res);
        end
        if (flags_now() !== e.flg) begin
          errors++;
          $display("FAIL %s flags: got %b expected %b", e.nm, flags_now(), e.flg);
        end
        if (cyc - e.start_cyc != 14) begin
          errors++;
          $display("FAIL %s latency: got %0d expected 14", e.nm, cyc - e.start_cyc);
        end
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [5:0] ef,
                        input bit chk_busy, input bit intrude);
    exp_t e;
    int   n = 0;
    bit   got = 0;
    bit   bsy_ok = 1;
    e.nm = nm; e.res = er; e.flg = ef; e.start_cyc = cyc + 1;
    sb.push_back(e);
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = 16'hFFFF;
    operand2 = 16'hFFFF;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      start = intrude && (n == 3);
      if (intrude && n == 3) begin
        operand1 = 16'h3C00;
        operand2 = 16'h4200;
      end
      if (done) got = 1;
      else if (!busy && n <= 14) bsy_ok = 0;
    end
    start = 1'b0;
    if (chk_busy) begin
      checks++;
      if (!bsy_ok) begin
        errors++;
        $display("FAIL %s busy: busy dropped before done (got 0, expected 1)", nm);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
    end
    @(negedge clk);
  endtask

  initial begin
    int dc;
    #12;
    checks++;
    if ({busy, done, result, flags_now()} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b expected all 0",
               busy, done, result, flags_now());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_6_by_2",    16'h4600, 16'h4000, 16'h4200, F_NONE,        1, 0);
    run_op("div_1_by_3",    16'h3C00, 16'h4200, 16'h3555, F_NONE,        0, 0);
    run_op("neg_6_by_2",    16'hC600, 16'h4000, 16'hC200, F_NONE,        0, 0);
    run_op("div_by_zero",   16'h4000, 16'h0000, 16'h7C00, F_INF | F_DBZ, 0, 0);
    run_op("zero_by_zero",  16'h0000, 16'h0000, 16'h7E00, F_NAN,         0, 0);
    run_op("overflow",      16'h7BFF, 16'h0400, 16'h7C00, F_OVF,         0, 0);
    run_op("underflow",     16'h0400, 16'h7BFF, 16'h0000, F_UNF,         0, 0);
    run_op("inf_by_fin",    16'h7C00, 16'h4000, 16'h7C00, F_INF,         0, 0);
    run_op("neg_by_zero",   16'hC000, 16'h0000, 16'hFC00, F_INF | F_DBZ, 0, 0);
    run_op("fin_by_inf",    16'h4000, 16'h7C00, 16'h0000, F_ZERO,        0, 0);
    run_op("zero_by_fin",   16'h0000, 16'h4000, 16'h0000, F_ZERO,        0, 0);
    run_op("inf_by_inf",    16'h7C00, 16'h7C00, 16'h7E00, F_NAN,         0, 0);
    run_op("nan_operand",   16'h7E00, 16'h3C00, 16'h7E00, F_NAN,         0, 0);

    // Start pulse with fresh operands while dividing must be ignored.
    dc = done_cnt;
    run_op("intrude_start", 16'h4600, 16'h4000, 16'h4200, F_NONE,        0, 1);
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - dc != 1) begin
      errors++;
      $display("FAIL intrude_done_count: got %0d done pulses expected 1", done_cnt - dc);
    end

    // Reset in the middle of the iteration phase aborts silently.
    dc = done_cnt;
    operand1 = 16'h4600;
    operand2 = 16'h4000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (result !== 16'h0000 || flags_now() !== F_NONE) begin
      errors++;
      $display("FAIL midreset_outputs: got result=%h flags=%b expected 0000 000000",
               result, flags_now());
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != dc) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses expected 0", done_cnt - dc);
    end
    run_op("after_reset",   16'h3C00, 16'h3C00, 16'h3C00, F_NONE,        0, 0);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
